// File: rtl/msg_play_arbiter.sv
// ============================================================================
//  Module   : msg_play_arbiter
//  Purpose  : Round-robin sequencer sharing one message ROM between two
//             requesters; walks character indices at a programmable pace.
//             Optional abort of an unwanted playback via MSG_ABORT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_play_arbiter #(
  parameter int IDX_W  = 4,
  parameter int PACE_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [PACE_W-1:0] pace_div,
  input  logic [IDX_W-1:0]  msg_len,
  output logic              rom_sel,
  output logic [IDX_W-1:0]  rom_addr,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [1:0]        done,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EMIT = 3'd2,
    S_PACE = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_len_q;
  logic [PACE_W-1:0]   r_pace_cnt;
  logic                r_last_grant;
  logic                w_grant;
  logic                w_handshake;
  logic                w_last_char;
  logic                w_abort;

  // Tie goes to whichever requester was not served last.
  assign w_grant     = req[1] & (~req[0] | ~r_last_grant);
  assign w_handshake = (r_state == S_EMIT) && char_ready;
  assign w_last_char = (rom_addr == (r_len_q - IDX_W'(1)));

`ifdef MSG_ABORT_EN
  assign w_abort = ~req[rom_sel];
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    char_valid  = 1'b0;
    busy        = 1'b1;
    done        = 2'b00;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req != 2'b00) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (msg_len == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        char_valid = 1'b1;
        if (w_handshake) begin
          w_state_nxt = w_last_char ? S_DONE : S_PACE;
        end
      end
      S_PACE: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_pace_cnt == '0) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_DONE: begin
        done        = rom_sel ? 2'b10 : 2'b01;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: grant, ROM address, loaded length, pace counter, fairness bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_sel      <= 1'b0;
      rom_addr     <= '0;
      r_len_q      <= '0;
      r_pace_cnt   <= '0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            rom_sel  <= w_grant;
            rom_addr <= '0;
          end
        end
        S_LOAD: begin
          r_len_q <= msg_len;
          if (w_abort) begin
            r_last_grant <= rom_sel;
          end
        end
        S_EMIT: begin
          if (w_handshake && !w_last_char) begin
            rom_addr   <= rom_addr + IDX_W'(1);
            r_pace_cnt <= pace_div;
          end
        end
        S_PACE: begin
          if (w_abort) begin
            r_last_grant <= rom_sel;
          end else if (r_pace_cnt != '0) begin
            r_pace_cnt <= r_pace_cnt - PACE_W'(1);
          end
        end
        S_DONE: begin
          r_last_grant <= rom_sel;
        end
        default: begin
          r_last_grant <= r_last_grant;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_msg_play_arbiter.sv
// ============================================================================
//  Module   : tb_msg_play_arbiter
//  Purpose  : Directed bench for msg_play_arbiter with a character/done
//             scoreboard and a behavioural two-message ROM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msg_play_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [11:0] pace_div;
  logic [3:0]  msg_len;
  logic        rom_sel;
  logic [3:0]  rom_addr;
  logic        char_valid;
  logic        char_ready;
  logic [1:0]  done;
  logic        busy;

  logic [3:0]  len0;
  logic [3:0]  len1;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_q[$];
  int          done_q[$];

  always #5 clk = ~clk;

  assign msg_len = rom_sel ? len1 : len0;

  msg_play_arbiter #(.IDX_W(4), .PACE_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .pace_div   (pace_div),
    .msg_len    (msg_len),
    .rom_sel    (rom_sel),
    .rom_addr   (rom_addr),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .done       (done),
    .busy       (busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input int sel, input int len);
    for (int a = 0; a < len; a++) exp_q.push_back(sel * 16 + a);
    done_q.push_back(sel == 1 ? 2 : 1);
  endtask

  task automatic wait_addr(input int a, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (int'(rom_addr) == a) hit = 1'b1;
      else cyc();
    end
    if (!hit) check(tag, 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (char_valid) hit = 1'b1;
      else cyc();
    end
    if (!hit) check(tag, 0, 1);
  endtask

  task automatic wait_done(input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (done != 2'b00) hit = 1'b1;
      else cyc();
    end
    if (!hit) check(tag, 0, 1);
  endtask

  // Scoreboard: every handshake and every done pulse must match the queues.
  always @(negedge clk) begin
    if (!reset && char_valid && char_ready) begin
      if (exp_q.size() == 0) check("hs_unexpected", 1, 0);
      else check("hs_char", int'({rom_sel, rom_addr}), exp_q.pop_front());
    end
    if (!reset && done != 2'b00) begin
      if (done_q.size() == 0) check("done_unexpected", int'(done), 0);
      else check("done_pulse", int'(done), done_q.pop_front());
    end
  end

  initial begin
    int nd;
    reset = 1'b1; req = 2'b00; pace_div = '0; char_ready = 1'b1;
    len0 = 4'd9; len1 = 4'd7;
    cyc(); cyc();
    check("rst_sel",   int'(rom_sel), 0);
    check("rst_addr",  int'(rom_addr), 0);
    check("rst_valid", int'(char_valid), 0);
    check("rst_done",  int'(done), 0);
    check("rst_busy",  int'(busy), 0);
    reset = 1'b0;

    // 1: single paced request
    pace_div = 12'd2;
    push_msg(0, 9);
    req = 2'b01;
    cyc();
    check("t1_load_valid", int'(char_valid), 0);
    check("t1_load_busy", int'(busy), 1);
    cyc();
    for (int k = 0; k < 9; k++) begin
      check("t1_valid", int'(char_valid), 1);
      cyc();
      if (k < 8) begin
        for (int g = 0; g < 3; g++) begin
          check("t1_gap", int'(char_valid), 0);
          cyc();
        end
      end
    end
    check("t1_done", int'(done), 1);
    check("t1_done_busy", int'(busy), 1);
    req = 2'b00;
    cyc();
    check("t1_idle_busy", int'(busy), 0);
    check("t1_idle_done", int'(done), 0);

    // 2: round robin from reset with both requesting
    reset = 1'b1; cyc(); reset = 1'b0;
    pace_div = 12'd0;
    push_msg(0, 9); push_msg(1, 7); push_msg(0, 9);
    req = 2'b11;
    cyc();
    check("t2_first_grant", int'(rom_sel), 0);
    nd = 0;
    for (int i = 0; i < 300 && nd < 3; i++) begin
      cyc();
      if (done != 2'b00) begin
        nd++;
        if (nd == 3) req = 2'b00;
      end
    end
    check("t2_done_count", nd, 3);
    cyc();
    check("t2_idle_busy", int'(busy), 0);

    // 3: backpressure on index 3
    pace_div = 12'd1;
    push_msg(0, 9);
    req = 2'b01;
    wait_addr(3, "t3_reach_addr3");
    char_ready = 1'b0;
    wait_valid("t3_reach_valid");
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", int'(char_valid), 1);
      check("t3_stall_addr", int'(rom_addr), 3);
      check("t3_stall_sel", int'(rom_sel), 0);
      cyc();
    end
    check("t3_hold_addr", int'(rom_addr), 3);
    char_ready = 1'b1;
    cyc();
    check("t3_advance_addr", int'(rom_addr), 4);
    check("t3_advance_valid", int'(char_valid), 0);
    wait_done("t3_done_timeout");
    req = 2'b00;
    cyc();

    // 4: empty message from requester 1
    len1 = 4'd0;
    done_q.push_back(2);
    req = 2'b10;
    cyc();
    check("t4_load_busy", int'(busy), 1);
    check("t4_load_valid", int'(char_valid), 0);
    check("t4_load_done", int'(done), 0);
    cyc();
    check("t4_done", int'(done), 2);
    check("t4_done_busy", int'(busy), 1);
    req = 2'b00;
    cyc();
    check("t4_idle_busy", int'(busy), 0);
    check("t4_idle_done", int'(done), 0);
    len1 = 4'd7;

    // 5: reset in the middle of a message
    pace_div = 12'd0;
    push_msg(0, 9);
    req = 2'b01;
    wait_addr(4, "t5_reach_addr4");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    done_q.delete();
    check("t5_rst_sel", int'(rom_sel), 0);
    check("t5_rst_addr", int'(rom_addr), 0);
    check("t5_rst_valid", int'(char_valid), 0);
    check("t5_rst_done", int'(done), 0);
    check("t5_rst_busy", int'(busy), 0);
    push_msg(0, 9);
    cyc();
    check("t5_restart_sel", int'(rom_sel), 0);
    cyc();
    check("t5_restart_valid", int'(char_valid), 1);
    check("t5_restart_addr", int'(rom_addr), 0);
    wait_done("t5_done_timeout");
    req = 2'b00;
    cyc();

`ifdef MSG_ABORT_EN
    // 6: requester 1 drops its request while pacing
    pace_div = 12'd3;
    for (int a = 0; a < 3; a++) exp_q.push_back(16 + a);
    req = 2'b10;
    wait_addr(3, "t6_reach_addr3");
    req = 2'b00;
    cyc();
    check("t6_abort_busy", int'(busy), 0);
    check("t6_abort_valid", int'(char_valid), 0);
    check("t6_abort_done", int'(done), 0);
    push_msg(0, 9);
    req = 2'b11;
    cyc();
    check("t6_regrant_sel", int'(rom_sel), 0);
    wait_done("t6_done_timeout");
    req = 2'b00;
    cyc();
`endif

    repeat (3) cyc();
    check("sb_chars_left", exp_q.size(), 0);
    check("sb_done_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
